// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the read-side FIFO drain controller.
package fifo_drain_pkg;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_read_drain_if.sv
// FIFO read port plus downstream valid/ready stream seen by the drain controller.
interface fifo_read_drain_if #(
  parameter int unsigned width = 32
) ();

  logic             empty;
  logic [width-1:0] rdata;
  logic             red_enable;
  logic [width-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    input  empty, rdata, m_ready,
    output red_enable, m_data, m_valid, m_last
  );

  modport slave (
    output empty, rdata, m_ready,
    input  red_enable, m_data, m_valid, m_last
  );

endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry head/tail output buffer; encoded state doubles as occupancy.
module fifo_out_buf
  import fifo_drain_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic             clk_r,
  input  logic             reset_r,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [width-1:0] head_data
);

  buf_state_e       state_q, state_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;

  always_ff @(posedge clk_r or negedge reset_r) begin
    if (!reset_r) begin
      state_q <= S0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      S0: begin
        if (wr_en) begin
          head_d  = wr_data;
          state_d = S1;
        end
      end
      S1: begin
        if (wr_en && pop) begin
          head_d = wr_data;
        end else if (wr_en) begin
          tail_d  = wr_data;
          state_d = S2;
        end else if (pop) begin
          state_d = S0;
        end
      end
      S2: begin
        // Write+pop here is excluded by the credit rule; handled anyway as a shift.
        if (pop) begin
          head_d = tail_q;
          if (wr_en) tail_d = wr_data;
          else       state_d = S1;
        end
      end
      default: state_d = S0;
    endcase
  end

  assign occ       = state_q;
  assign head_data = head_q;

endmodule

// File: rtl/fifo_read_drain.sv
// Read-domain drain: credit-limited pops into a 2-entry buffer, framed valid/ready output.
module fifo_read_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned width     = 32,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic               clk_r,
  input  logic               reset_r,
  fifo_read_drain_if.master  bus,
  output logic [CNT_W-1:0]   word_cnt
);

  localparam int unsigned     FW      = $clog2(FRAME_LEN + 1);
  localparam logic [FW-1:0]   LastCnt = FW'(FRAME_LEN - 1);

  logic [1:0]       occ;
  logic [width-1:0] head_data;
  logic             inflight_q;
  logic             m_valid;
  logic             m_last;
  logic             pop;
  logic [2:0]       credit;
  logic             red_enable;
  logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] word_cnt_q;

  fifo_out_buf #(
    .width(width)
  ) u_out_buf (
    .clk_r    (clk_r),
    .reset_r  (reset_r),
    .wr_en    (inflight_q),
    .wr_data  (bus.rdata),
    .pop      (pop),
    .occ      (occ),
    .head_data(head_data)
  );

  assign credit  = {1'b0, occ} + {2'b0, inflight_q};
  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & bus.m_ready;
  assign m_last  = m_valid && (frame_cnt_q == LastCnt);

  // Pop-aware credit: a word leaving this cycle frees a slot for the pop issued now.
  assign red_enable = reset_r && !bus.empty && (credit < (3'(BUF_DEPTH) + {2'b0, pop}));

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (pop) frame_cnt_d = m_last ? '0 : frame_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_r or negedge reset_r) begin
    if (!reset_r) begin
      inflight_q  <= 1'b0;
      frame_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      inflight_q  <= red_enable;
      frame_cnt_q <= frame_cnt_d;
      word_cnt_q  <= word_cnt_q + {{(CNT_W-1){1'b0}}, pop};
    end
  end

  assign bus.red_enable = red_enable;
  assign bus.m_data     = head_data;
  assign bus.m_valid    = m_valid;
  assign bus.m_last     = m_last;
  assign word_cnt       = word_cnt_q;

  assert property (@(posedge clk_r) disable iff (!reset_r) credit <= 3'(BUF_DEPTH));

endmodule

// File: tb/tb_fifo_read_drain.sv
// Directed bench for fifo_read_drain with a behavioural FIFO read port and in-order scoreboard.
module tb_fifo_read_drain;
  import fifo_drain_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned FL = 16;

  logic             clk_r   = 1'b0;
  logic             reset_r = 1'b0;
  logic [CNT_W-1:0] word_cnt;

  fifo_read_drain_if #(.width(W)) bus ();

  fifo_read_drain #(
    .width    (W),
    .FRAME_LEN(FL)
  ) dut (
    .clk_r   (clk_r),
    .reset_r (reset_r),
    .bus     (bus),
    .word_cnt(word_cnt)
  );

  always #5 clk_r = ~clk_r;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] popped;
  logic [31:0] expw;
  bit          ren_s      = 1'b0;
  bit          empty_gate = 1'b0;
  int          issued     = 0;
  int          delivered  = 0;
  int          tb_frame   = 0;
  int          last_seen  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_r);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int i;
    i = 0;
    while (i < max_cyc && (exp_q.size() != 0 || bus.m_valid)) begin
      @(negedge clk_r);
      i++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // FIFO read port model: pop on the edge after red_enable, data visible the following cycle.
  always @(posedge clk_r) begin
    if (ren_s) begin
      chk("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      popped = (fifo_q.size() != 0) ? fifo_q.pop_front() : 32'hdead_beef;
      issued++;
    end
    #2;
    if (ren_s) bus.rdata = popped;
    bus.empty = (fifo_q.size() == 0) || empty_gate;
  end

  // Scoreboard on the downstream stream.
  always @(negedge clk_r) begin
    ren_s = bus.red_enable;
    if (reset_r) begin
      chk("credit_le_2", 32'((issued - delivered) <= 2), 32'd1);
      if (bus.m_valid && bus.m_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        expw = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
        chk("m_data", bus.m_data, expw);
        chk("m_last", 32'(bus.m_last), 32'(tb_frame == FL - 1));
        if (bus.m_last) last_seen++;
        tb_frame = (tb_frame == FL - 1) ? 0 : tb_frame + 1;
        delivered++;
      end
    end
  end

  initial begin
    int ren_cnt;
    int guard;
    bus.empty   = 1'b1;
    bus.rdata   = '0;
    bus.m_ready = 1'b0;

    // Power-on reset values.
    repeat (3) step();
    @(negedge clk_r);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_red_enable", 32'(bus.red_enable), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_m_data", bus.m_data, 32'd0);
    step();
    reset_r = 1'b1;
    step();

    // Streaming 64 words with ready held high: 2-cycle start, then 1 word/cycle.
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 64; i++) push(32'(i));
    @(negedge clk_r);
    chk("lat_t0_valid", 32'(bus.m_valid), 32'd0);
    chk("lat_t0_ren", 32'(bus.red_enable), 32'd1);
    @(negedge clk_r);
    chk("lat_t1_valid", 32'(bus.m_valid), 32'd0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_r);
      chk("stream_valid", 32'(bus.m_valid), 32'd1);
    end
    @(negedge clk_r);
    chk("stream_end_valid", 32'(bus.m_valid), 32'd0);
    chk("stream_word_cnt", 32'(word_cnt), 32'd64);
    chk("stream_last_cnt", 32'(last_seen), 32'd4);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: 8 words queued, ready low for 10 cycles.
    step();
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(32'h100 + 32'(i));
    ren_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_r);
      if (bus.red_enable) ren_cnt++;
      if (i >= 2) begin
        chk("bp_valid", 32'(bus.m_valid), 32'd1);
        chk("bp_hold_data", bus.m_data, 32'h101);
      end
    end
    chk("bp_ren_cycles", 32'(ren_cnt), 32'd2);
    step();
    bus.m_ready = 1'b1;
    drain(50, "bp_drain");
    chk("bp_word_cnt", 32'(word_cnt), 32'd72);

    // Empty flag toggling every cycle.
    step();
    for (int i = 1; i <= 10; i++) push(32'h200 + 32'(i));
    for (int i = 0; i < 40; i++) begin
      step();
      empty_gate = ~empty_gate;
      @(negedge clk_r);
      if (bus.empty) chk("ren_while_empty", 32'(bus.red_enable), 32'd0);
    end
    step();
    empty_gate = 1'b0;
    drain(50, "toggle_drain");
    chk("toggle_word_cnt", 32'(word_cnt), 32'd82);

    // Random ready over 1000 words.
    step();
    for (int i = 0; i < 1000; i++) push($urandom);
    guard = 0;
    while (guard < 6000 && (exp_q.size() != 0 || bus.m_valid)) begin
      step();
      bus.m_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    bus.m_ready = 1'b1;
    @(negedge clk_r);
    chk("rand_word_cnt", 32'(word_cnt), 32'd1082);

    // Asynchronous reset mid-stream with the buffer full.
    step();
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(32'h300 + 32'(i));
    repeat (6) step();
    chk("pre_rst_head", bus.m_data, 32'h301);
    chk("pre_rst_valid", 32'(bus.m_valid), 32'd1);
    reset_r = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    issued    = 0;
    delivered = 0;
    tb_frame  = 0;
    #1;
    chk("arst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("arst_m_last", 32'(bus.m_last), 32'd0);
    chk("arst_red_enable", 32'(bus.red_enable), 32'd0);
    chk("arst_word_cnt", 32'(word_cnt), 32'd0);
    chk("arst_m_data", bus.m_data, 32'd0);
    repeat (2) step();
    reset_r = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_r);
      chk("no_stale_valid", 32'(bus.m_valid), 32'd0);
    end
    step();
    for (int i = 1; i <= 3; i++) push(32'h400 + 32'(i));
    drain(20, "post_rst_drain");
    chk("post_rst_word_cnt", 32'(word_cnt), 32'd3);

    // word_cnt wrap: bring it to 65534, then 3 more words land on 1.
    step();
    for (int i = 0; i < 65531; i++) push(32'(i));
    drain(70000, "wrap_fill_drain");
    chk("wrap_pre_cnt", 32'(word_cnt), 32'hfffe);
    step();
    for (int i = 1; i <= 3; i++) push(32'h500 + 32'(i));
    drain(20, "wrap_drain");
    chk("wrap_word_cnt", 32'(word_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
